// File: rtl/sdram_timer_bank.sv
// sdram_timer_bank: bank of NUM_CH independent down-counters for SDRAM timing
// (tRCD, tRP, tRFC, refresh interval, ...). Each channel runs one-shot or
// periodic (auto-reload). It reports a level "done" when its count is zero
// and a registered one-cycle "expire" pulse when it times out.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   load        per-channel load strobe
//   load_value  channel i value at [i*WIDTH +: WIDTH]
//   load_per    periodic-mode select, sampled with load
//   clear       per-channel abort (count and mode to 0, reload kept)
//   pause       freeze all counting (only with SDRAM_TIMER_PAUSE_EN)
//   done        count == 0 per channel (combinational from count register)
//   expire      one-cycle timeout pulse per channel (registered)
//   all_done    AND of done
//
// Build option: define SDRAM_TIMER_PAUSE_EN to add the pause input.

module sdram_timer_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*WIDTH-1:0]   load_value,
    input  logic [NUM_CH-1:0]         load_per,
    input  logic [NUM_CH-1:0]         clear,
`ifdef SDRAM_TIMER_PAUSE_EN
    input  logic                      pause,
`endif
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         expire,
    output logic                      all_done
);

    localparam int unsigned CW = WIDTH;

    // Global run enable: counting and auto-reload happen only while run is high.
    logic run;
`ifdef SDRAM_TIMER_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] rel_q, rel_d;
        logic          per_q, per_d;
        logic          exp_q, exp_d;
        logic [CW-1:0] val;

        assign val = load_value[i*CW +: CW];

        // Next state: clear beats load beats decrement.
        always_comb begin
            cnt_d = cnt_q;
            rel_d = rel_q;
            per_d = per_q;
            exp_d = 1'b0;
            if (clear[i]) begin
                cnt_d = '0;
                per_d = 1'b0;
            end else if (load[i]) begin
                cnt_d = val;
                rel_d = val;
                per_d = load_per[i];
            end else if (run && (cnt_q != '0)) begin
                if (cnt_q == CW'(1)) begin
                    exp_d = 1'b1;
                    cnt_d = (per_q && (rel_q != '0)) ? rel_q : '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                rel_q <= '0;
                per_q <= 1'b0;
                exp_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                rel_q <= rel_d;
                per_q <= per_d;
                exp_q <= exp_d;
            end
        end

        assign done[i]   = (cnt_q == '0);
        assign expire[i] = exp_q;
    end

    assign all_done = &done;

endmodule

// File: tb/tb_sdram_timer_bank.sv
// Self-checking bench for sdram_timer_bank (NUM_CH=4, WIDTH=16).
// Reference model tracks, per channel, when it was loaded, with what value
// and mode; done/expire are then derived from elapsed cycles.

module tb_sdram_timer_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    load = '0;
    logic [NCH*W-1:0]  load_value = '0;
    logic [NCH-1:0]    load_per = '0;
    logic [NCH-1:0]    clear = '0;
    logic              pause = 1'b0;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    expire;
    logic              all_done;

    sdram_timer_bank #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .load_per   (load_per),
        .clear      (clear),
`ifdef SDRAM_TIMER_PAUSE_EN
        .pause      (pause),
`endif
        .done       (done),
        .expire     (expire),
        .all_done   (all_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int  cyc = 0;
    bit  act    [NCH];
    bit  per_m  [NCH];
    int  ld_cyc [NCH];
    int  n_val  [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(NCH); c++) begin
            act[c] = 1'b0;
            per_m[c] = 1'b0;
            ld_cyc[c] = 0;
            n_val[c] = 0;
        end
    endtask

    function automatic logic [NCH-1:0] exp_done();
        logic [NCH-1:0] r;
        for (int c = 0; c < int'(NCH); c++)
            r[c] = !act[c] || (!per_m[c] && (cyc >= ld_cyc[c] + n_val[c]));
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_expire();
        logic [NCH-1:0] r;
        for (int c = 0; c < int'(NCH); c++) begin
            if (!act[c] || cyc <= ld_cyc[c])
                r[c] = 1'b0;
            else if (per_m[c])
                r[c] = ((cyc - ld_cyc[c]) % n_val[c]) == 0;
            else
                r[c] = (cyc == ld_cyc[c] + n_val[c]);
        end
        return r;
    endfunction

    // Apply inputs for one edge, update model, check outputs just after it.
    task automatic step(input logic [NCH-1:0] ld, input logic [NCH-1:0] clr,
                        input logic [NCH-1:0] pm, input logic [NCH*W-1:0] vals,
                        input bit full_check);
        logic [NCH-1:0] ed;
        load = ld; clear = clr; load_per = pm; load_value = vals;
        @(posedge clk);
        cyc++;
        for (int c = 0; c < int'(NCH); c++) begin
            if (clr[c]) begin
                act[c] = 1'b0;
            end else if (ld[c]) begin
                n_val[c]  = int'(vals[c*W +: W]);
                act[c]    = (n_val[c] != 0);
                per_m[c]  = pm[c];
                ld_cyc[c] = cyc;
            end
        end
        #1;
        ed = exp_done();
        if (full_check || expire != '0 || exp_expire() != '0 || done != ed) begin
            chk("done", 32'(done), 32'(ed));
            chk("expire", 32'(expire), 32'(exp_expire()));
            chk("all_done", 32'(all_done), 32'(&ed));
        end
        load = '0; clear = '0; load_per = '0;
    endtask

    function automatic logic [NCH*W-1:0] pack1(input int ch, input logic [W-1:0] v);
        logic [NCH*W-1:0] r;
        r = '0;
        r[ch*W +: W] = v;
        return r;
    endfunction

    initial begin
        logic [NCH-1:0]   r_ld, r_clr, r_pm;
        logic [NCH*W-1:0] r_v;

        model_reset();
        #12;
        chk("rst_done", 32'(done), 32'hF);
        chk("rst_expire", 32'(expire), 32'h0);
        chk("rst_all_done", 32'(all_done), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // idle after reset
        repeat (20) step('0, '0, '0, '0, 1'b1);

        // one-shot ch0 load 5
        step(4'b0001, '0, '0, pack1(0, 16'd5), 1'b1);
        repeat (7) step('0, '0, '0, '0, 1'b1);

        // periodic ch3 load 3, then clear
        step(4'b1000, '0, 4'b1000, pack1(3, 16'd3), 1'b1);
        repeat (10) step('0, '0, '0, '0, 1'b1);
        step('0, 4'b1000, '0, '0, 1'b1);
        repeat (6) step('0, '0, '0, '0, 1'b1);

        // priority: ch1 at count 1, clear+load together
        step(4'b0010, '0, '0, pack1(1, 16'd2), 1'b1);
        step('0, '0, '0, '0, 1'b1);
        step(4'b0010, 4'b0010, '0, pack1(1, 16'd7), 1'b1);
        repeat (3) step('0, '0, '0, '0, 1'b1);
        // load only at count 1: restart, no expire
        step(4'b0010, '0, '0, pack1(1, 16'd2), 1'b1);
        step('0, '0, '0, '0, 1'b1);
        step(4'b0010, '0, '0, pack1(1, 16'd7), 1'b1);
        repeat (9) step('0, '0, '0, '0, 1'b1);

        // edge values: load 0 one-shot and periodic, periodic 1
        step(4'b0100, '0, '0, pack1(2, 16'd0), 1'b1);
        step(4'b0100, '0, 4'b0100, pack1(2, 16'd0), 1'b1);
        repeat (3) step('0, '0, '0, '0, 1'b1);
        step(4'b0100, '0, 4'b0100, pack1(2, 16'd1), 1'b1);
        repeat (6) step('0, '0, '0, '0, 1'b1);
        step('0, 4'b0100, '0, '0, 1'b1);
        step('0, '0, '0, '0, 1'b1);

        // randomized traffic
        repeat (3000) begin
            for (int c = 0; c < int'(NCH); c++) begin
                r_ld[c]  = ($urandom_range(0, 7) == 0);
                r_clr[c] = ($urandom_range(0, 15) == 0);
                r_pm[c]  = $urandom_range(0, 1) == 1;
                r_v[c*W +: W] = W'($urandom_range(0, 12));
            end
            step(r_ld, r_clr, r_pm, r_v, 1'b1);
        end
        step('0, 4'hF, '0, '0, 1'b1);

        // full-range one-shot on ch0; only cycles with activity or discrepancy are checked
        step(4'b0001, '0, '0, pack1(0, 16'hFFFF), 1'b1);
        repeat (65533) step('0, '0, '0, '0, 1'b0);
        repeat (3) step('0, '0, '0, '0, 1'b1);

        // asynchronous reset mid-count
        step(4'b1111, '0, 4'b0101, {16'd9, 16'd6, 16'd8, 16'd5}, 1'b1);
        step('0, '0, '0, '0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_done", 32'(done), 32'hF);
        chk("async_rst_all_done", 32'(all_done), 32'h1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step('0, '0, '0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
